// File: rtl/piso_frame_tx_if.sv
// Handshake and serial-line bundle for the piso_frame_tx transmitter.
// The producer side (master) offers a word with LOAD and watches READY;
// the transmitter side (slave) drives the serial line and frame status.
interface piso_frame_tx_if #(
   parameter int WIDTH = 8
);
   logic [WIDTH-1:0] D_IN;
   logic             LOAD;
   logic             READY;
   logic             SO;
   logic             BUSY;
   logic             DONE;

   modport master (
      output D_IN,
      output LOAD,
      input  READY,
      input  SO,
      input  BUSY,
      input  DONE
   );

   modport slave (
      input  D_IN,
      input  LOAD,
      output READY,
      output SO,
      output BUSY,
      output DONE
   );
endinterface

// File: rtl/piso_frame_tx.sv
// Parallel-in serial-out frame transmitter for the bit-serial D-line link.
// Frame on SO: start bit (0), WIDTH data bits LSB-first, optional even
// parity bit, stop bit (1). Idle line level is 1. Every output is driven
// from a register whose next value is derived from the next FSM state, so
// no combinational path exists from LOAD/D_IN to any output.
module piso_frame_tx #(
   parameter int WIDTH     = 8,
   parameter bit PARITY_EN = 1'b1
) (
   input logic            C,
   input logic            RE,
   piso_frame_tx_if.slave bus
);

   // Counter must be able to hold WIDTH itself, hence WIDTH+1 codes.
   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4
   } state_t;

   // Even parity over the captured word: XOR of all data bits, so the
   // data plus the parity bit always carry an even number of ones.
   function automatic logic even_parity_bit(input logic [WIDTH-1:0] word);
      even_parity_bit = ^word;
   endfunction

   state_t           state_r;
   state_t           state_nxt_s;

   logic [WIDTH-1:0] shift_r;
   logic [WIDTH-1:0] shift_nxt_s;
   logic [CW-1:0]    cnt_r;
   logic [CW-1:0]    cnt_nxt_s;
   logic             par_r;
   logic             par_nxt_s;

   logic             ready_r;
   logic             so_r;
   logic             busy_r;
   logic             done_r;
   logic             ready_nxt_s;
   logic             so_nxt_s;
   logic             busy_nxt_s;
   logic             done_nxt_s;

   logic             accept_s;

   // A load is taken only from IDLE; in every other state LOAD is ignored.
   always_comb begin
      accept_s = 1'b0;
      if (state_r == ST_IDLE) begin
         accept_s = bus.LOAD;
      end else begin
         accept_s = 1'b0;
      end
   end

   // FSM state register.
   always_ff @(posedge C or posedge RE) begin
      if (RE) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // FSM next-state logic: walk start, data, optional parity, stop.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (accept_s) begin
               state_nxt_s = ST_START;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_START: begin
            state_nxt_s = ST_DATA;
         end
         ST_DATA: begin
            if (cnt_r == LAST_IDX) begin
               if (PARITY_EN) begin
                  state_nxt_s = ST_PARITY;
               end else begin
                  state_nxt_s = ST_STOP;
               end
            end else begin
               state_nxt_s = ST_DATA;
            end
         end
         ST_PARITY: begin
            state_nxt_s = ST_STOP;
         end
         ST_STOP: begin
            state_nxt_s = ST_IDLE;
         end
         default: begin
            state_nxt_s = ST_IDLE;
         end
      endcase
   end

   // Datapath next values: capture word and its parity on accept, shift
   // right and count while data bits are on the line, otherwise hold.
   always_comb begin
      shift_nxt_s = shift_r;
      cnt_nxt_s   = cnt_r;
      par_nxt_s   = par_r;
      if (accept_s) begin
         shift_nxt_s = bus.D_IN;
         cnt_nxt_s   = {CW{1'b0}};
         par_nxt_s   = even_parity_bit(bus.D_IN);
      end else if (state_r == ST_DATA) begin
         shift_nxt_s = shift_r >> 1;
         cnt_nxt_s   = cnt_r + {{(CW-1){1'b0}}, 1'b1};
         par_nxt_s   = par_r;
      end else begin
         shift_nxt_s = shift_r;
         cnt_nxt_s   = cnt_r;
         par_nxt_s   = par_r;
      end
   end

   // Datapath registers: shift register, bit counter and latched parity.
   always_ff @(posedge C or posedge RE) begin
      if (RE) begin
         shift_r <= {WIDTH{1'b0}};
         cnt_r   <= {CW{1'b0}};
         par_r   <= 1'b0;
      end else begin
         shift_r <= shift_nxt_s;
         cnt_r   <= cnt_nxt_s;
         par_r   <= par_nxt_s;
      end
   end

   // FSM output logic: output values for the state being entered, so the
   // output registers line up exactly with the state register.
   always_comb begin
      ready_nxt_s = 1'b1;
      so_nxt_s    = 1'b1;
      busy_nxt_s  = 1'b0;
      done_nxt_s  = 1'b0;
      case (state_nxt_s)
         ST_IDLE: begin
            ready_nxt_s = 1'b1;
            so_nxt_s    = 1'b1;
            busy_nxt_s  = 1'b0;
            done_nxt_s  = 1'b0;
         end
         ST_START: begin
            ready_nxt_s = 1'b0;
            so_nxt_s    = 1'b0;
            busy_nxt_s  = 1'b1;
            done_nxt_s  = 1'b0;
         end
         ST_DATA: begin
            ready_nxt_s = 1'b0;
            so_nxt_s    = shift_nxt_s[0];
            busy_nxt_s  = 1'b1;
            done_nxt_s  = 1'b0;
         end
         ST_PARITY: begin
            ready_nxt_s = 1'b0;
            so_nxt_s    = par_nxt_s;
            busy_nxt_s  = 1'b1;
            done_nxt_s  = 1'b0;
         end
         ST_STOP: begin
            ready_nxt_s = 1'b0;
            so_nxt_s    = 1'b1;
            busy_nxt_s  = 1'b1;
            done_nxt_s  = 1'b1;
         end
         default: begin
            ready_nxt_s = 1'b1;
            so_nxt_s    = 1'b1;
            busy_nxt_s  = 1'b0;
            done_nxt_s  = 1'b0;
         end
      endcase
   end

   // Output registers; reset forces the idle line level at once.
   always_ff @(posedge C or posedge RE) begin
      if (RE) begin
         ready_r <= 1'b1;
         so_r    <= 1'b1;
         busy_r  <= 1'b0;
         done_r  <= 1'b0;
      end else begin
         ready_r <= ready_nxt_s;
         so_r    <= so_nxt_s;
         busy_r  <= busy_nxt_s;
         done_r  <= done_nxt_s;
      end
   end

   assign bus.READY = ready_r;
   assign bus.SO    = so_r;
   assign bus.BUSY  = busy_r;
   assign bus.DONE  = done_r;

endmodule

// File: tb/tb_piso_frame_tx.sv
// Testbench for piso_frame_tx: one default instance (WIDTH=8, parity on)
// and one WIDTH=4 instance without parity. Expected frames come from a
// reference model that builds the bit list straight from the frame rules.
module tb_piso_frame_tx;

   logic clk;
   logic rst0;
   logic rst1;

   piso_frame_tx_if #(.WIDTH(8)) bus0 ();
   piso_frame_tx_if #(.WIDTH(4)) bus1 ();

   piso_frame_tx #(.WIDTH(8), .PARITY_EN(1'b1)) dut0 (
      .C   (clk),
      .RE  (rst0),
      .bus (bus0)
   );

   piso_frame_tx #(.WIDTH(4), .PARITY_EN(1'b0)) dut1 (
      .C   (clk),
      .RE  (rst1),
      .bus (bus1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int   checks;
   int   errors;
   logic exp_q[$];
   logic so_v;
   logic busy_v;
   logic done_v;
   logic ready_v;

   // Reference frame: start 0, data LSB-first, even parity if enabled, stop 1.
   function automatic void make_frame(input int unsigned w, input int width, input bit pen);
      int unsigned m;
      m = w & ((32'd1 << width) - 32'd1);
      exp_q.delete();
      exp_q.push_back(1'b0);
      for (int i = 0; i < width; i++) begin
         exp_q.push_back(logic'((m >> i) & 32'd1));
      end
      if (pen) begin
         exp_q.push_back(logic'($countones(m) % 2));
      end
      exp_q.push_back(1'b1);
   endfunction

   task automatic chk(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %b expected %b at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic sample(input int sel);
      if (sel == 1) begin
         so_v = bus1.SO; busy_v = bus1.BUSY; done_v = bus1.DONE; ready_v = bus1.READY;
      end else begin
         so_v = bus0.SO; busy_v = bus0.BUSY; done_v = bus0.DONE; ready_v = bus0.READY;
      end
   endtask

   task automatic set_in(input int sel, input logic load, input logic [15:0] data);
      if (sel == 1) begin
         bus1.LOAD = load; bus1.D_IN = data[3:0];
      end else begin
         bus0.LOAD = load; bus0.D_IN = data[7:0];
      end
   endtask

   task automatic chk_idle(input int sel, input string tag);
      sample(sel);
      chk({tag, "_so"},    so_v,    1'b1);
      chk({tag, "_busy"},  busy_v,  1'b0);
      chk({tag, "_done"},  done_v,  1'b0);
      chk({tag, "_ready"}, ready_v, 1'b1);
   endtask

   task automatic idle_cycles(input int sel, input int n);
      for (int k = 0; k < n; k++) begin
         step();
         chk_idle(sel, "idle");
      end
   endtask

   // Called with the start bit already on SO; walks the whole frame, then
   // checks the idle cycle that follows. Optionally raises LOAD with
   // D_IN=all ones during cycle 'intrude' for one cycle.
   task automatic frame_check(input int sel, input int intrude);
      int f;
      f = exp_q.size();
      for (int j = 0; j < f; j++) begin
         sample(sel);
         chk("frame_so",    so_v,    exp_q[j]);
         chk("frame_busy",  busy_v,  1'b1);
         chk("frame_done",  done_v,  logic'(j == f - 1));
         chk("frame_ready", ready_v, 1'b0);
         if (intrude >= 0 && j == intrude) begin
            set_in(sel, 1'b1, 16'hFFFF);
         end else if (intrude >= 0 && j == intrude + 1) begin
            set_in(sel, 1'b0, 16'hFFFF);
         end
         step();
      end
      chk_idle(sel, "post_frame");
   endtask

   task automatic send(input int sel, input int unsigned w, input int intrude);
      if (sel == 1) make_frame(w, 4, 1'b0);
      else          make_frame(w, 8, 1'b1);
      set_in(sel, 1'b1, 16'(w));
      step();
      set_in(sel, 1'b0, 16'h0000);
      frame_check(sel, intrude);
   endtask

   initial begin
      int unsigned w;
      int          intr;
      int          f;
      checks = 0;
      errors = 0;
      rst0 = 1'b1;
      rst1 = 1'b1;
      set_in(0, 1'b0, 16'h0000);
      set_in(1, 1'b0, 16'h0000);

      // 1: reset held three cycles (LOAD high must be ignored), then idle.
      #1;
      set_in(0, 1'b1, 16'h00A5);
      for (int k = 0; k < 3; k++) begin
         step();
         chk_idle(0, "rst0");
         chk_idle(1, "rst1");
      end
      set_in(0, 1'b0, 16'h0000);
      rst0 = 1'b0;
      rst1 = 1'b0;
      for (int k = 0; k < 10; k++) begin
         step();
         chk_idle(0, "idle0");
         chk_idle(1, "idle1");
      end

      // 2: single frame 8'hA5.
      send(0, 32'hA5, -1);
      idle_cycles(0, 1);

      // 3: odd number of ones -> parity bit 1.
      send(0, 32'h07, -1);
      idle_cycles(0, 1);

      // 4: LOAD with 8'hFF in the 4th frame cycle must be ignored.
      send(0, 32'hA5, 3);
      idle_cycles(0, 3);

      // Randomized frames with random idle gaps and random intruding loads.
      for (int n = 0; n < 8; n++) begin
         w = $urandom_range(0, 255);
         f = 11;
         intr = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, f - 2)) : -1;
         send(0, w, intr);
         idle_cycles(0, int'($urandom_range(0, 2)));
      end

      // 5: LOAD held high -> frames back to back with one idle cycle.
      make_frame(32'h3C, 8, 1'b1);
      set_in(0, 1'b1, 16'h003C);
      for (int n = 0; n < 3; n++) begin
         step();
         frame_check(0, -1);
      end
      set_in(0, 1'b0, 16'h0000);
      idle_cycles(0, 2);

      // 6: WIDTH=4, no parity; reset during the 3rd data bit.
      make_frame(32'hB, 4, 1'b0);
      set_in(1, 1'b1, 16'h000B);
      step();
      set_in(1, 1'b0, 16'h0000);
      for (int j = 0; j < 4; j++) begin
         sample(1);
         chk("abort_so", so_v, exp_q[j]);
         chk("abort_busy", busy_v, 1'b1);
         if (j < 3) step();
      end
      #1;
      rst1 = 1'b1;
      #1;
      chk_idle(1, "abort_async");
      for (int k = 0; k < 2; k++) begin
         step();
         chk_idle(1, "abort_hold");
      end
      rst1 = 1'b0;
      idle_cycles(1, 2);
      send(1, 32'hB, -1);
      idle_cycles(1, 1);

      // Randomized frames on the narrow, parity-less instance.
      for (int n = 0; n < 5; n++) begin
         w = $urandom_range(0, 15);
         intr = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 4)) : -1;
         send(1, w, intr);
         idle_cycles(1, int'($urandom_range(0, 2)));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
